// File: rtl/vga_pkg.sv
// Shared types and default sizing for the VGA framebuffer arbiter.
package vga_pkg;

  typedef logic [2:0] rgb_t;

  localparam int unsigned DEPTH_DEF      = 19200;
  localparam int unsigned STARVE_MAX_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Display read port and pixel writer handshake of the framebuffer arbiter.
interface vga_fb_arbiter_if #(
  parameter int unsigned ADDR_W = 15
) ();

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_rvalid;
  vga_pkg::rgb_t     disp_rdata;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  vga_pkg::rgb_t     wr_data;
  logic              wr_ready;

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data,
    input  disp_rvalid, disp_rdata, wr_ready
  );

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data,
    output disp_rvalid, disp_rdata, wr_ready
  );

endinterface

// File: rtl/fb_wr_skid.sv
// One-entry write buffer: accepts on valid/ready, issues whenever not blocked.
module fb_wr_skid
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  rgb_t              in_data,
  input  logic              accept_en,
  input  logic              blocked,
  output logic              in_ready_c,
  output logic              issue_c,
  output logic              full,
  output logic [ADDR_W-1:0] out_addr,
  output rgb_t              out_data
);

  assign issue_c    = full & ~blocked;
  // Refill in the same cycle the held entry leaves, so back-to-back writes stream.
  assign in_ready_c = accept_en & (~full | issue_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else if (in_valid && in_ready_c) begin
      full     <= 1'b1;
      out_addr <= in_addr;
      out_data <= in_data;
    end else if (issue_c) begin
      full     <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads, buffered pixel writes and
// a background screen clear share one synchronous RAM by fixed priority.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_fb_arbiter_if.slave   bus,
  input  logic              clr_start,
  input  rgb_t              clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_starve,
  input  logic              starve_clr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output rgb_t              mem_wdata,
  input  rgb_t              mem_rdata
);

  localparam int unsigned CNT_W = $clog2(DEPTH);
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  arb_state_t        state;
  logic [CNT_W-1:0]  clr_cnt;
  rgb_t              clr_col;
  logic [STV_W-1:0]  starve_cnt;
  logic              rvalid_q;

  logic              buf_full;
  logic              buf_issue;
  logic [ADDR_W-1:0] buf_addr;
  rgb_t              buf_data;
  logic              clr_issue;
  logic              last_clr;
  logic              buf_blocked;
  logic              starve_set;

  fb_wr_skid #(.ADDR_W(ADDR_W)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (bus.wr_valid),
    .in_addr    (bus.wr_addr),
    .in_data    (bus.wr_data),
    .accept_en  (state == ST_IDLE),
    .blocked    (bus.disp_req),
    .in_ready_c (bus.wr_ready),
    .issue_c    (buf_issue),
    .full       (buf_full),
    .out_addr   (buf_addr),
    .out_data   (buf_data)
  );

  assign bus.disp_rvalid = rvalid_q;
  assign bus.disp_rdata  = mem_rdata;

  assign buf_blocked = buf_full & bus.disp_req;
  assign starve_set  = buf_blocked && (starve_cnt == STV_W'(STARVE_MAX - 1));
  assign last_clr    = clr_issue && (clr_cnt == CNT_W'(DEPTH - 1));

  // Fixed-priority grant: display read, then buffered write, then clear fill.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    clr_issue = 1'b0;
    if (bus.disp_req) begin
      mem_en   = 1'b1;
      mem_addr = bus.disp_addr;
    end else if (buf_issue) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = buf_addr;
      mem_wdata = buf_data;
    end else if (state == ST_CLEAR) begin
      clr_issue = 1'b1;
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ADDR_W'(clr_cnt);
      mem_wdata = clr_col;
    end
    if (!rst_n) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      clr_col    <= '0;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
      rvalid_q   <= 1'b0;
      starve_cnt <= '0;
      wr_starve  <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      rvalid_q <= bus.disp_req;

      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            clr_col  <= clr_color;
            clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_issue) begin
            clr_cnt <= clr_cnt + CNT_W'(1);
            if (last_clr) begin
              state    <= ST_IDLE;
              clr_busy <= 1'b0;
              clr_done <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Saturating run length of display-blocked cycles with a write waiting.
      if (!buf_blocked) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STV_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end

      if (starve_set) begin
        wr_starve <= 1'b1;
      end else if (starve_clr) begin
        wr_starve <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized and directed checks of vga_fb_arbiter against a per-cycle
// behavioural model of the arbitration, write buffer, clear and starvation rules.
module tb_vga_fb_arbiter;

  localparam int unsigned ADDR_W     = 15;
  localparam int          DEPTH      = 19200;
  localparam int          STARVE_MAX = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              clr_start  = 1'b0;
  logic [2:0]        clr_color  = 3'b000;
  logic              starve_clr = 1'b0;
  logic              clr_busy, clr_done, wr_starve;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_wdata;
  logic [2:0]        mem_rdata;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  vga_fb_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_start  (clr_start),
    .clr_color  (clr_color),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .wr_starve  (wr_starve),
    .starve_clr (starve_clr),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Framebuffer RAM, one-cycle read latency.
  logic [2:0] ram [DEPTH] = '{default: 3'b000};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state.
  logic [2:0]        ref_mem [DEPTH] = '{default: 3'b000};
  bit                m_clear, m_full, m_rvalid, m_done, m_starve;
  int                m_idx, m_cnt;
  logic [2:0]        m_color, m_bdata, m_rdata;
  logic [ADDR_W-1:0] m_baddr;

  // Observed values of the last sampled cycle.
  logic              o_en, o_we, o_rdy, o_rv, o_busy, o_done, o_st;
  logic [ADDR_W-1:0] o_addr;
  logic [2:0]        o_wd, o_rd;
  logic [27:0]       obs_v, exp_v;

  function automatic logic [27:0] pack(input logic en, we, input logic [ADDR_W-1:0] a,
                                       input logic [2:0] wd, input logic rdy, rv,
                                       input logic [2:0] rd, input logic busy, done, st);
    logic [ADDR_W-1:0] am;
    logic [2:0]        wdm, rdm;
    am  = en ? a : '0;
    wdm = (en && we) ? wd : 3'b000;
    rdm = rv ? rd : 3'b000;
    return {en, we, am, wdm, rdy, rv, rdm, busy, done, st};
  endfunction

  task automatic model_reset();
    m_clear = 0; m_full = 0; m_rvalid = 0; m_done = 0; m_starve = 0;
    m_idx = 0; m_cnt = 0; m_color = 3'b000; m_bdata = 3'b000; m_rdata = 3'b000;
    m_baddr = '0;
  endtask

  task automatic drive(input bit dreq, input int daddr, input bit wv, input int waddr,
                       input logic [2:0] wdata);
    bus.disp_req  = dreq;
    bus.disp_addr = ADDR_W'(daddr);
    bus.wr_valid  = wv;
    bus.wr_addr   = ADDR_W'(waddr);
    bus.wr_data   = wdata;
  endtask

  // One clock: sample DUT mid-cycle, form the model's expectation, advance the model.
  task automatic tick();
    bit                g_rd, g_buf, g_clr, e_rdy, blocked, set;
    logic [ADDR_W-1:0] e_addr;
    logic [2:0]        e_wd;
    @(negedge clk);
    o_en = mem_en; o_we = mem_we; o_addr = mem_addr; o_wd = mem_wdata;
    o_rdy = bus.wr_ready; o_rv = bus.disp_rvalid; o_rd = bus.disp_rdata;
    o_busy = clr_busy; o_done = clr_done; o_st = wr_starve;
    obs_v = pack(o_en, o_we, o_addr, o_wd, o_rdy, o_rv, o_rd, o_busy, o_done, o_st);

    g_rd  = bus.disp_req;
    g_buf = !bus.disp_req && m_full;
    g_clr = !bus.disp_req && !m_full && m_clear;
    e_addr = g_rd ? bus.disp_addr : (g_buf ? m_baddr : ADDR_W'(m_idx));
    e_wd   = g_buf ? m_bdata : m_color;
    e_rdy  = !m_clear && (!m_full || g_buf);
    exp_v = pack(g_rd | g_buf | g_clr, g_buf | g_clr, e_addr, e_wd, e_rdy,
                 m_rvalid, m_rdata, m_clear, m_done, m_starve);

    m_rvalid = g_rd;
    if (g_rd) m_rdata = ref_mem[bus.disp_addr];
    if (g_buf) ref_mem[m_baddr] = m_bdata;
    if (g_clr) ref_mem[m_idx] = m_color;
    m_done = g_clr && (m_idx == DEPTH - 1);

    blocked = m_full && bus.disp_req;
    set = blocked && (m_cnt == STARVE_MAX - 1);
    if (!blocked) m_cnt = 0;
    else if (m_cnt < STARVE_MAX) m_cnt = m_cnt + 1;
    if (set) m_starve = 1;
    else if (starve_clr) m_starve = 0;

    if (bus.wr_valid && e_rdy) begin
      m_full = 1; m_baddr = bus.wr_addr; m_bdata = bus.wr_data;
    end else if (g_buf) begin
      m_full = 0;
    end

    if (m_clear) begin
      if (g_clr) begin
        if (m_idx == DEPTH - 1) m_clear = 0;
        m_idx = m_idx + 1;
      end
    end else if (clr_start) begin
      m_clear = 1; m_idx = 0; m_color = clr_color;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 3, 0, 0, 3'b000);
    #1 rst_n = 1'b0;
    #2;
    vectors++;
    if ({mem_en, mem_we, clr_busy, clr_done, bus.disp_rvalid, wr_starve} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 000000",
               {mem_en, mem_we, clr_busy, clr_done, bus.disp_rvalid, wr_starve});
    end
    repeat (2) @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 3'b000);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset_idle: got %h required %h", obs_v, exp_v);
      end
    end
    vectors++;
    if (o_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_wr_ready: got %b required 1", o_rdy);
    end
  endtask

  task automatic test_read();
    drive(0, 0, 1, 5, 3'b100);
    tick();
    drive(1, 5, 0, 0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL read_cycle%0d: got %h required %h", i, obs_v, exp_v);
      end
      drive(0, 0, 0, 0, 3'b000);
    end
    tick();
    drive(1, 5, 0, 0, 3'b000);
    tick();
    drive(0, 0, 0, 0, 3'b000);
    tick();
    vectors++;
    if (o_rv !== 1'b1 || o_rd !== 3'b100) begin
      miscompares++;
      $display("FAIL read_addr5: got rvalid=%b rdata=%b required rvalid=1 rdata=100", o_rv, o_rd);
    end
  endtask

  task automatic test_blocked_write();
    drive(1, 100, 1, 7, 3'b010);
    tick();
    drive(1, 101, 0, 0, 3'b000);
    tick();
    vectors++;
    if (o_rdy !== 1'b0 || o_we !== 1'b0) begin
      miscompares++;
      $display("FAIL blocked_hold: got ready=%b we=%b required 0 0", o_rdy, o_we);
    end
    drive(0, 0, 0, 0, 3'b000);
    tick();
    vectors++;
    if ({o_en, o_we, o_addr, o_wd} !== {1'b1, 1'b1, ADDR_W'(7), 3'b010}) begin
      miscompares++;
      $display("FAIL blocked_issue: got en=%b we=%b addr=%0d data=%b required 1 1 7 010",
               o_en, o_we, o_addr, o_wd);
    end
    drive(1, 7, 0, 0, 3'b000);
    tick();
    drive(0, 0, 0, 0, 3'b000);
    tick();
    vectors++;
    if (o_rv !== 1'b1 || o_rd !== 3'b010) begin
      miscompares++;
      $display("FAIL blocked_readback: got rvalid=%b rdata=%b required 1 010", o_rv, o_rd);
    end
  endtask

  task automatic test_starve();
    drive(1, 0, 1, 20, 3'b011);
    tick();
    drive(1, 1, 0, 0, 3'b000);
    for (int k = 1; k <= 16; k++) begin
      tick();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL starve_run%0d: got %h required %h", k, obs_v, exp_v);
      end
    end
    vectors++;
    if (o_st !== 1'b0) begin
      miscompares++;
      $display("FAIL starve_early: got %b required 0 after 15 blocked cycles", o_st);
    end
    starve_clr = 1'b1;
    tick();
    vectors++;
    if (o_st !== 1'b1) begin
      miscompares++;
      $display("FAIL starve_set: got %b required 1 after 16 blocked cycles", o_st);
    end
    starve_clr = 1'b0;
    tick();
    vectors++;
    if (o_st !== 1'b0) begin
      miscompares++;
      $display("FAIL starve_clear: got %b required 0", o_st);
    end
    // Issue frees the buffer and refills it; a clear coinciding with the set loses.
    drive(0, 0, 1, 21, 3'b110);
    tick();
    drive(1, 2, 0, 0, 3'b000);
    for (int k = 1; k <= 16; k++) begin
      starve_clr = (k == 16);
      tick();
    end
    starve_clr = 1'b0;
    tick();
    vectors++;
    if (o_st !== 1'b1 || obs_v !== exp_v) begin
      miscompares++;
      $display("FAIL starve_set_wins: got %b (%h) required 1 (%h)", o_st, obs_v, exp_v);
    end
    drive(0, 0, 0, 0, 3'b000);
    starve_clr = 1'b1;
    tick();
    starve_clr = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1),
            $urandom_range(0, 2) != 0, $urandom_range(0, DEPTH - 1), 3'($urandom));
      starve_clr = ($urandom_range(0, 15) == 0);
      tick();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h required %h", i, obs_v, exp_v);
      end
    end
    starve_clr = 1'b0;
    drive(0, 0, 0, 0, 3'b000);
    tick();
    tick();
  endtask

  task automatic test_clear();
    int writes, dones, bad, first_addr, n;
    bit seen_write, rdy_in_clear;
    writes = 0; dones = 0; bad = 0; first_addr = -1; n = 0;
    seen_write = 0; rdy_in_clear = 0;
    drive(1, 4, 1, 9, 3'b110);
    tick();
    drive(1, 5, 0, 0, 3'b000);
    clr_start = 1'b1;
    clr_color = 3'b001;
    tick();
    clr_start = 1'b0;
    clr_color = 3'b000;
    while (dones == 0 && n < 45000) begin
      drive(n % 2 == 1, $urandom_range(0, DEPTH - 1),
            (m_idx < DEPTH - 10) && ($urandom_range(0, 1) == 1),
            $urandom_range(0, DEPTH - 1), 3'b111);
      clr_start = (n == 1000);
      clr_color = (n == 1000) ? 3'b111 : 3'b000;
      tick();
      if (o_en && o_we) begin
        writes++;
        if (!seen_write) first_addr = int'(o_addr);
        seen_write = 1;
      end
      if (o_done) dones++;
      if (o_busy && o_rdy) rdy_in_clear = 1;
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL clear_cycle%0d: got %h required %h", n, obs_v, exp_v);
      end
      n++;
    end
    clr_start = 1'b0;
    drive(0, 0, 0, 0, 3'b000);
    tick();
    if (o_done) dones++;
    vectors++;
    if (first_addr != 9) begin
      miscompares++;
      $display("FAIL clear_drain_first: got addr %0d required 9", first_addr);
    end
    vectors++;
    if (writes != DEPTH + 1) begin
      miscompares++;
      $display("FAIL clear_write_count: got %0d required %0d", writes, DEPTH + 1);
    end
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL clear_done_pulses: got %0d required 1", dones);
    end
    vectors++;
    if (rdy_in_clear) begin
      miscompares++;
      $display("FAIL clear_wr_ready: got 1 during clear required 0");
    end
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== 3'b001) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL clear_fill: got %0d entries not 001 required 0", bad);
    end
  endtask

  task automatic test_reset_in_clear();
    int n;
    n = 0;
    drive(0, 0, 0, 0, 3'b000);
    clr_start = 1'b1;
    clr_color = 3'b101;
    tick();
    clr_start = 1'b0;
    while (m_idx != 100 && n < 400) begin
      tick();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL rstclr_run%0d: got %h required %h", n, obs_v, exp_v);
      end
      n++;
    end
    #2;
    bus.disp_req = 1'b1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({clr_busy, clr_done, mem_en, mem_we} !== 4'b0000) begin
      miscompares++;
      $display("FAIL rstclr_async: got busy=%b done=%b en=%b we=%b required 0000",
               clr_busy, clr_done, mem_en, mem_we);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rstclr_hold%0d: got busy=%b done=%b required 0 0", i, clr_busy, clr_done);
      end
    end
    drive(0, 0, 0, 0, 3'b000);
    model_reset();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (o_rdy !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rstclr_release: got ready=%b busy=%b done=%b required 1 0 0",
               o_rdy, o_busy, o_done);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL rstclr_after%0d: got %h required %h", i, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 3'b000);
    model_reset();
    test_reset();
    test_read();
    test_blocked_write();
    test_starve();
    test_random();
    test_clear();
    test_reset_in_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
